// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU between two requesters. It holds the issue register, tracks the owner of
// every op in flight and routes results back. Define ALU_ARB_RR_EN for a strict round-robin grant.

module alu_arb_owner_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic vld_in,
  input  logic own_in,
  output logic vld,
  output logic own
);
  // A flush only kills entries owned by req0 (own == 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      own <= 1'b0;
    end else begin
      vld <= vld_in && !(flush && !own_in);
      own <= own_in;
    end
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int LAT      = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_valid,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t       req0, req1, sel;
  logic       gnt0, gnt1, hs, block0;
  logic [LAT:0] vld_pipe, own_pipe, vld_src, own_src;

  assign req0 = {req0_op, req0_a, req0_b};
  assign req1 = {req1_op, req1_a, req1_b};

`ifdef ALU_ARB_RR_EN
  // last_gnt1 resets to 1 so that req0 wins the first contested cycle.
  logic last_gnt1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_gnt1 <= 1'b1;
    else if (hs) last_gnt1 <= gnt1;
  end
  assign block0 = req1_valid && !last_gnt1;
`else
  logic [3:0] wait_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (req1_valid && gnt1)
      wait_cnt <= '0;
    else if (req1_valid && (wait_cnt != 4'(MAX_WAIT)))
      wait_cnt <= wait_cnt + 4'd1;
  end
  assign block0 = req1_valid && (wait_cnt == 4'(MAX_WAIT));
`endif

  // Grants are gated by reset so the ready outputs also read 0 while reset is held.
  assign gnt0       = rst_n && req0_valid && !flush && !block0;
  assign gnt1       = rst_n && req1_valid && !gnt0;
  assign hs         = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign sel        = gnt1 ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      alu_valid <= hs;
      if (hs) begin
        alu_op <= sel.op;
        alu_a  <= sel.a;
        alu_b  <= sel.b;
      end
    end
  end

  // Owner entry s is live during cycle c+1+s. Stage LAT lines up with alu_result.
  assign vld_src = {vld_pipe[LAT-1:0], hs};
  assign own_src = {own_pipe[LAT-1:0], gnt1};

  for (genvar s = 0; s <= LAT; s++) begin : g_stage
    alu_arb_owner_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .vld_in (vld_src[s]),
      .own_in (own_src[s]),
      .vld    (vld_pipe[s]),
      .own    (own_pipe[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
    end else begin
      resp0_valid <= vld_pipe[LAT] && !own_pipe[LAT] && !flush;
      resp1_valid <= vld_pipe[LAT] && own_pipe[LAT];
      if (vld_pipe[LAT]) resp_data <= alu_result;
    end
  end

  assign busy = alu_valid || (|vld_pipe) || resp0_valid || resp1_valid;
endmodule
